// File: rtl/qspi_xip_ctrl_sac_if.sv
// -----------------------------------------------------------------------------
// qspi_xip_ctrl_sac_if
// AHB-Lite slave-side bundle for the QSPI XIP controller.
//   HSEL, HADDR, HTRANS, HWRITE, HREADY : master -> slave address phase
//   HREADYOUT, HRDATA                   : slave -> master data phase
// Modports: master (bus driver / bench), slave (controller).
// -----------------------------------------------------------------------------
interface qspi_xip_ctrl_sac_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/qspi_xip_ctrl_sac.sv
// -----------------------------------------------------------------------------
// qspi_xip_ctrl_sac
// Read-only AHB-Lite XIP controller with a direct-mapped line cache in front of
// an SST26-class quad SPI flash. Misses are filled with a Quad I/O read (EBh):
// command, 24-bit line address, mode byte 0x00, dummy clocks, then one line of
// data. sck runs at HCLK/2 and idles low.
//
// Ports:
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   ahb (slave)        AHB-Lite HSEL/HADDR/HTRANS/HWRITE/HREADY in,
//                      HREADYOUT/HRDATA out
//   flush              pulse: invalidate every cache line
//   sck, ce_n          flash clock and chip enable (active low)
//   din, dout, douten  SIO pads via external tri-state wrapper
//   hit_cnt, miss_cnt  saturating counters, only with QSPI_XIP_PERF_CNT_EN
//
// Optional feature macro: QSPI_XIP_PERF_CNT_EN (adds hit_cnt/miss_cnt).
// -----------------------------------------------------------------------------
module qspi_xip_ctrl_sac #(
    parameter int NUM_LINES    = 16,
    parameter int LINE_WORDS   = 4,
    parameter int DUMMY_CYCLES = 4,
    parameter int ADDR_WIDTH   = 24
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    qspi_xip_ctrl_sac_if.slave       ahb,
    input  logic                     flush,
    output logic                     sck,
    output logic                     ce_n,
    input  logic [3:0]               din,
    output logic [3:0]               dout,
    output logic                     douten
`ifdef QSPI_XIP_PERF_CNT_EN
    ,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
`endif
);

    localparam int OFF_W     = $clog2(LINE_WORDS);
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int TAG_W     = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam int LINE_BITS = 32 * LINE_WORDS;
    localparam int CNT_W     = 8;

    localparam logic [7:0]       CMD_EB    = 8'hEB;
    localparam logic [CNT_W-1:0] LEN_DUMMY = CNT_W'(DUMMY_CYCLES);
    localparam logic [CNT_W-1:0] LEN_DATA  = CNT_W'(8 * LINE_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                 st_r, st_s;
    logic                   ph_r;          // 0: sck low half, 1: sck high half
    logic [CNT_W-1:0]       cnt_r;         // sck periods elapsed in current state
    logic                   sck_r, ce_n_r, douten_r, hready_r;
    logic [3:0]             dout_r;
    logic [31:0]            hrdata_r;
    logic [IDX_W-1:0]       fill_idx_r;
    logic [TAG_W-1:0]       fill_tag_r;
    logic [OFF_W-1:0]       fill_off_r;
    logic [23:0]            fill_addr_r;
    logic [LINE_BITS-1:0]   line_buf_r;
    logic                   flush_pend_r;

    logic [LINE_BITS-1:0]   data_r [NUM_LINES];
    logic [TAG_W-1:0]       tag_r  [NUM_LINES];
    logic [NUM_LINES-1:0]   valid_r;

    logic [OFF_W-1:0]       req_off_s;
    logic [IDX_W-1:0]       req_idx_s;
    logic [TAG_W-1:0]       req_tag_s;
    logic [23:0]            line_addr_s;
    logic                   rd_s, hit_s, fill_start_s, seg_end_s, done_wr_s;
    logic                   unused_s;

    // Length in sck periods of each serial state.
    function automatic logic [CNT_W-1:0] seg_len(input state_t s);
        case (s)
            ST_CMD:   seg_len = 8'd8;
            ST_ADDR:  seg_len = 8'd6;
            ST_MODE:  seg_len = 8'd2;
            ST_DUMMY: seg_len = LEN_DUMMY;
            ST_DATA:  seg_len = LEN_DATA;
            default:  seg_len = 8'd1;
        endcase
    endfunction

    // Nibble presented on dout for sck period c of state s.
    function automatic logic [3:0] out_nib(input state_t s, input logic [CNT_W-1:0] c,
                                           input logic [23:0] a);
        logic [23:0] sh;
        sh = a << {c[2:0], 2'b00};
        case (s)
            ST_CMD:  out_nib = {3'b000, CMD_EB[3'd7 - c[2:0]]};
            ST_ADDR: out_nib = sh[23:20];
            default: out_nib = 4'h0;
        endcase
    endfunction

    assign req_off_s   = ahb.HADDR[OFF_W+1:2];
    assign req_idx_s   = ahb.HADDR[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag_s   = ahb.HADDR[ADDR_WIDTH-1:OFF_W+IDX_W+2];
    assign line_addr_s = 24'({req_tag_s, req_idx_s}) << (OFF_W + 2);
    assign unused_s    = ^{ahb.HADDR[31:ADDR_WIDTH], ahb.HADDR[1:0], ahb.HTRANS[0]};

    // hready_r is only high while idle, so a stalled pipelined address phase is
    // never taken until the fill has returned its word.
    assign rd_s         = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY & hready_r & ~ahb.HWRITE;
    assign hit_s        = valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s);
    assign fill_start_s = (st_r == ST_IDLE) & rd_s & ~hit_s;
    assign seg_end_s    = ph_r & (cnt_r == (seg_len(st_r) - 8'd1));
    assign done_wr_s    = (st_r == ST_DONE) & ~ph_r;

    // Fill FSM next-state logic.
    always_comb begin
        st_s = st_r;
        case (st_r)
            ST_IDLE:  if (fill_start_s) st_s = ST_CMD;   else st_s = ST_IDLE;
            ST_CMD:   if (seg_end_s)    st_s = ST_ADDR;  else st_s = ST_CMD;
            ST_ADDR:  if (seg_end_s)    st_s = ST_MODE;  else st_s = ST_ADDR;
            ST_MODE:  if (seg_end_s)    st_s = (DUMMY_CYCLES == 32'sd0) ? ST_DATA : ST_DUMMY;
                      else              st_s = ST_MODE;
            ST_DUMMY: if (seg_end_s)    st_s = ST_DATA;  else st_s = ST_DUMMY;
            ST_DATA:  if (seg_end_s)    st_s = ST_DONE;  else st_s = ST_DATA;
            ST_DONE:  if (ph_r)         st_s = ST_IDLE;  else st_s = ST_DONE;
            default:                    st_s = ST_IDLE;
        endcase
    end

    // State register, flash pin drivers and AHB data-phase outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st_r        <= ST_IDLE;
            ph_r        <= 1'b0;
            cnt_r       <= '0;
            sck_r       <= 1'b0;
            ce_n_r      <= 1'b1;
            dout_r      <= 4'h0;
            douten_r    <= 1'b0;
            hready_r    <= 1'b1;
            hrdata_r    <= 32'h0;
            fill_idx_r  <= '0;
            fill_tag_r  <= '0;
            fill_off_r  <= '0;
            fill_addr_r <= 24'h0;
            line_buf_r  <= '0;
        end else begin
            st_r <= st_s;
            case (st_r)
                ST_IDLE: begin
                    ph_r  <= 1'b0;
                    cnt_r <= '0;
                    if (rd_s && hit_s) begin
                        hrdata_r <= data_r[req_idx_s][32*req_off_s +: 32];
                    end else if (fill_start_s) begin
                        hready_r    <= 1'b0;
                        ce_n_r      <= 1'b0;
                        douten_r    <= 1'b1;
                        dout_r      <= out_nib(ST_CMD, 8'd0, line_addr_s);
                        fill_idx_r  <= req_idx_s;
                        fill_tag_r  <= req_tag_s;
                        fill_off_r  <= req_off_s;
                        fill_addr_r <= line_addr_s;
                    end
                end
                // Two cycles: first commits the line, second returns the word.
                ST_DONE: begin
                    ph_r <= ~ph_r;
                    if (ph_r) begin
                        hrdata_r <= line_buf_r[32*fill_off_r +: 32];
                        hready_r <= 1'b1;
                    end
                end
                default: begin
                    ph_r  <= ~ph_r;
                    sck_r <= ~ph_r;
                    if (!ph_r) begin
                        // sck rising: nibble n lands at bit (n^1)*4, giving
                        // high-nibble-first bytes packed little-endian.
                        if (st_r == ST_DATA) begin
                            line_buf_r[{cnt_r ^ 8'd1, 2'b00} +: 4] <= din;
                        end
                    end else if (seg_end_s) begin
                        cnt_r    <= '0;
                        dout_r   <= out_nib(st_s, 8'd0, fill_addr_r);
                        douten_r <= (st_s == ST_CMD) || (st_s == ST_ADDR) || (st_s == ST_MODE);
                        ce_n_r   <= (st_s == ST_DONE);
                    end else begin
                        cnt_r  <= cnt_r + 8'd1;
                        dout_r <= out_nib(st_r, cnt_r + 8'd1, fill_addr_r);
                    end
                end
            endcase
        end
    end

    // Line data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge HCLK) begin
        if (done_wr_s) begin
            data_r[fill_idx_r] <= line_buf_r;
        end
    end

    // Tags, valid bits and the flush-during-fill marker.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_r      <= '0;
            flush_pend_r <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid_r <= '0;
            end else if (done_wr_s && !flush_pend_r) begin
                valid_r[fill_idx_r] <= 1'b1;
            end
            if (done_wr_s) begin
                tag_r[fill_idx_r] <= fill_tag_r;
            end
            if ((st_r == ST_DONE) && ph_r) begin
                flush_pend_r <= 1'b0;
            end else if (flush && ((st_r != ST_IDLE) || fill_start_s)) begin
                flush_pend_r <= 1'b1;
            end
        end
    end

`ifdef QSPI_XIP_PERF_CNT_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    // Saturating hit/miss counters, cleared by flush.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hit_cnt_r  <= 32'h0;
            miss_cnt_r <= 32'h0;
        end else if (flush) begin
            hit_cnt_r  <= 32'h0;
            miss_cnt_r <= 32'h0;
        end else begin
            if (rd_s && hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (fill_start_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

    assign ahb.HREADYOUT = hready_r;
    assign ahb.HRDATA    = hrdata_r;
    assign sck           = sck_r;
    assign ce_n          = ce_n_r;
    assign dout          = dout_r;
    assign douten        = douten_r;

endmodule

// File: tb/tb_qspi_xip_ctrl_sac.sv
// -----------------------------------------------------------------------------
// tb_qspi_xip_ctrl_sac
// Directed bench for qspi_xip_ctrl_sac at default parameters, with a behavioural
// quad flash that answers EBh reads. Flash byte a holds a[7:0] ^ {a[9:8],6'b0},
// so bytes 0x00..0x3F equal their own address.
// -----------------------------------------------------------------------------
module tb_qspi_xip_ctrl_sac;
    localparam int D     = 4;
    localparam int STALL = 106;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        flush = 1'b0;
    logic        sck, ce_n, douten;
    logic [3:0]  din, dout;
`ifdef QSPI_XIP_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    qspi_xip_ctrl_sac_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    always #5 HCLK = ~HCLK;

    qspi_xip_ctrl_sac dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ahb     (bus.slave),
        .flush   (flush),
        .sck     (sck),
        .ce_n    (ce_n),
        .din     (din),
        .dout    (dout),
        .douten  (douten)
`ifdef QSPI_XIP_PERF_CNT_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    // Behavioural flash
    logic [7:0]  mem [0:1023];
    int          rcnt = 0;
    int          last_rcnt = 0;
    int          ce_falls = 0;
    int          nib_n;
    logic [9:0]  nib_b;
    logic [7:0]  cmd_cap = 8'h00;
    logic [23:0] addr_cap = 24'h0;
    logic [3:0]  din_r = 4'h0;
    assign din = din_r;

    always @(posedge sck or posedge ce_n) begin
        if (ce_n) begin
            if (rcnt != 0) last_rcnt = rcnt;
            rcnt = 0;
        end else begin
            rcnt = rcnt + 1;
            if (rcnt <= 8)       cmd_cap  = {cmd_cap[6:0], dout[0]};
            else if (rcnt <= 14) addr_cap = {addr_cap[19:0], dout};
        end
    end

    always @(negedge sck) begin
        if (!ce_n && cmd_cap == 8'hEB && rcnt >= 16 + D) begin
            nib_n = rcnt - 16 - D;
            nib_b = addr_cap[9:0] + 10'(nib_n / 2);
            din_r = nib_n[0] ? mem[nib_b][3:0] : mem[nib_b][7:4];
        end
    end

    always @(negedge ce_n) ce_falls = ce_falls + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge of the data phase.
    task automatic do_read(input logic [31:0] addr, input logic flush_addr, input int flush_at,
                           output logic [31:0] data, output int stall);
        bus.HSEL   = 1'b1;
        bus.HADDR  = addr;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        flush      = flush_addr;
        @(posedge HCLK); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        flush      = 1'b0;
        stall      = 0;
        while (!bus.HREADYOUT && stall < 1000) begin
            flush = (stall == flush_at);
            @(posedge HCLK); #1;
            flush = 1'b0;
            stall = stall + 1;
        end
        data = bus.HRDATA;
    endtask

    logic [31:0] rdata;
    int          stall;
    int          falls0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] a;
            a = i[9:0];
            mem[i] = a[7:0] ^ {a[9:8], 6'b000000};
        end
        bus.HSEL = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;

        #12;
        check("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        check("rst_sck", {31'h0, sck}, 32'h0);
        check("rst_ce_n", {31'h0, ce_n}, 32'h1);
        check("rst_dout", {28'h0, dout}, 32'h0);
        check("rst_douten", {31'h0, douten}, 32'h0);

        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Cold miss on line 0
        falls0 = ce_falls;
        do_read(32'h0, 1'b0, -1, rdata, stall);
        check("miss0_stall", stall, STALL);
        check("miss0_data", rdata, 32'h03020100);
        check("miss0_cmd", {24'h0, cmd_cap}, 32'h000000EB);
        check("miss0_addr", {8'h0, addr_cap}, 32'h0);
        check("miss0_sck_count", last_rcnt, 32'd52);
        check("miss0_ce_fall", ce_falls, falls0 + 1);

        // Hit in the same line
        do_read(32'h4, 1'b0, -1, rdata, stall);
        check("hit4_stall", stall, 32'd0);
        check("hit4_data", rdata, 32'h07060504);
        check("hit4_no_fill", ce_falls, falls0 + 1);
        check("hit4_ce_n", {31'h0, ce_n}, 32'h1);

        // Back-to-back hits
        bus.HSEL = 1'b1; bus.HADDR = 32'h8; bus.HTRANS = 2'b10;
        @(posedge HCLK); #1;
        bus.HADDR = 32'hC;
        check("b2b_8_ready", {31'h0, bus.HREADYOUT}, 32'h1);
        check("b2b_8_data", bus.HRDATA, 32'h0B0A0908);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        check("b2b_c_ready", {31'h0, bus.HREADYOUT}, 32'h1);
        check("b2b_c_data", bus.HRDATA, 32'h0F0E0D0C);

        // Flush coincident with a hit: hit served, line invalid afterwards
        do_read(32'h4, 1'b1, -1, rdata, stall);
        check("flushhit_stall", stall, 32'd0);
        check("flushhit_data", rdata, 32'h07060504);
        do_read(32'h8, 1'b0, -1, rdata, stall);
        check("postflush_stall", stall, STALL);
        check("postflush_data", rdata, 32'h0B0A0908);

        // Index conflict eviction
        do_read(32'h10, 1'b0, -1, rdata, stall);
        check("m10_stall", stall, STALL);
        check("m10_data", rdata, 32'h13121110);
        do_read(32'h110, 1'b0, -1, rdata, stall);
        check("m110_stall", stall, STALL);
        check("m110_data", rdata, 32'h53525150);
        check("m110_addr", {8'h0, addr_cap}, 32'h00000110);
        do_read(32'h10, 1'b0, -1, rdata, stall);
        check("evict_stall", stall, STALL);
        check("evict_data", rdata, 32'h13121110);

        // Write is ignored
        falls0 = ce_falls;
        bus.HSEL = 1'b1; bus.HADDR = 32'h30; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        check("wr_ready", {31'h0, bus.HREADYOUT}, 32'h1);
        check("wr_hrdata", bus.HRDATA, 32'h13121110);
        @(posedge HCLK); #1;
        check("wr_no_fill", ce_falls, falls0);

        // Flush during a fill
        do_read(32'h20, 1'b0, 50, rdata, stall);
        check("flushfill_stall", stall, STALL);
        check("flushfill_data", rdata, 32'h23222120);
        do_read(32'h20, 1'b0, -1, rdata, stall);
        check("refill20_stall", stall, STALL);

        // Asynchronous reset in the middle of DATA
        bus.HSEL = 1'b1; bus.HADDR = 32'h0; bus.HTRANS = 2'b10;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        repeat (60) @(posedge HCLK);
        #1;
        check("mid_ce_n", {31'h0, ce_n}, 32'h0);
        check("mid_ready", {31'h0, bus.HREADYOUT}, 32'h0);
        #1 HRESETn = 1'b0;
        #1;
        check("arst_ce_n", {31'h0, ce_n}, 32'h1);
        check("arst_ready", {31'h0, bus.HREADYOUT}, 32'h1);
        check("arst_douten", {31'h0, douten}, 32'h0);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;
        do_read(32'h0, 1'b0, -1, rdata, stall);
        check("postrst_stall", stall, STALL);
        check("postrst_data", rdata, 32'h03020100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
